// File: rtl/square_wave_analyzer.sv
// -----------------------------------------------------------------------------
// square_wave_analyzer
//
// Receive-side companion to the 8-bit square-wave generator. Slices a stream
// of 8-bit samples to a logic level using hysteresis thresholds, then reports
// edges, the period between the last two rising edges and the high time
// within that period. All durations are counted in accepted samples.
//
// Optional feature macro: GLITCH_FILTER_EN
//   defined   - an opposite classification must persist for MIN_RUN
//               consecutive accepted samples before the level changes.
//   undefined - the level changes on the first opposite sample and the
//               MIN_RUN parameter does not exist.
//
// Ports
//   clk           in   1      system clock, all logic on posedge
//   reset         in   1      synchronous, active-high reset
//   sample_in     in   8      input sample
//   sample_valid  in   1      sample_in is accepted when 1
//   level_out     out  1      current sliced level (0 while UNKNOWN)
//   rise_pulse    out  1      1-cycle pulse on an accepted low->high edge
//   fall_pulse    out  1      1-cycle pulse on an accepted high->low edge
//   period        out  CNT_W  samples between the last two rising edges
//   high_time     out  CNT_W  high samples within that period
//   meas_valid    out  1      1-cycle pulse, period/high_time updated
//   no_signal     out  1      sticky, set when the period counter saturates
//   state_dbg     out  2      FSM state (0 UNKNOWN, 1 LOW, 2 HIGH)
//
// Handshake: a sample is consumed on every posedge where sample_valid is 1;
// there is no back-pressure. On cycles with sample_valid 0 nothing changes
// except that the one-cycle pulses return to 0.
// -----------------------------------------------------------------------------
module square_wave_analyzer #(
    parameter int         CNT_W     = 16,
    parameter logic [7:0] HI_THRESH = 8'd192,
    parameter logic [7:0] LO_THRESH = 8'd64
`ifdef GLITCH_FILTER_EN
    ,
    parameter int         MIN_RUN   = 2
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       sample_in,
    input  logic             sample_valid,
    output logic             level_out,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             no_signal,
    output logic [1:0]       state_dbg
);

    localparam logic [1:0] ST_UNKNOWN = 2'd0;
    localparam logic [1:0] ST_LOW     = 2'd1;
    localparam logic [1:0] ST_HIGH    = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_MAX - CNT_ONE;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
    logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_time_q, high_time_d;
    logic             armed_q, armed_d;
    logic             no_signal_q, no_signal_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             meas_q, meas_d;

    logic is_hi, is_lo;
    logic take_rise, take_fall;
    logic sat_reached;

    assign is_hi = (sample_in >= HI_THRESH);
    assign is_lo = (sample_in <= LO_THRESH);

`ifdef GLITCH_FILTER_EN
    localparam int RUN_W = (MIN_RUN > 1) ? $clog2(MIN_RUN + 1) : 1;
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(MIN_RUN - 1);

    logic [RUN_W-1:0] run_q, run_d;

    // run_q counts consecutive opposite samples already seen; the edge is
    // taken on the MIN_RUN-th one. Mid or same-level samples restart it.
    always_comb begin
        take_rise = 1'b0;
        take_fall = 1'b0;
        run_d     = run_q;
        if (sample_valid) begin
            if ((state_q == ST_LOW && is_hi) || (state_q == ST_HIGH && is_lo)) begin
                if (run_q == RUN_LAST) begin
                    take_rise = (state_q == ST_LOW);
                    take_fall = (state_q == ST_HIGH);
                    run_d     = '0;
                end else begin
                    run_d = run_q + 1'b1;
                end
            end else begin
                run_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            run_q <= '0;
        end else begin
            run_q <= run_d;
        end
    end
`else
    always_comb begin
        take_rise = 1'b0;
        take_fall = 1'b0;
        if (sample_valid) begin
            take_rise = (state_q == ST_LOW) && is_hi;
            take_fall = (state_q == ST_HIGH) && is_lo;
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        per_cnt_d   = per_cnt_q;
        hi_cnt_d    = hi_cnt_q;
        period_d    = period_q;
        high_time_d = high_time_q;
        armed_d     = armed_q;
        no_signal_d = no_signal_q;
        rise_d      = 1'b0;
        fall_d      = 1'b0;
        meas_d      = 1'b0;
        sat_reached = 1'b0;

        if (sample_valid) begin
            // Level FSM. UNKNOWN settles on the first decisive sample
            // without an edge; mid samples never move the level.
            case (state_q)
                ST_UNKNOWN: begin
                    if (is_hi) begin
                        state_d = ST_HIGH;
                    end else if (is_lo) begin
                        state_d = ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (take_rise) begin
                        state_d = ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (take_fall) begin
                        state_d = ST_LOW;
                    end
                end
                default: state_d = ST_UNKNOWN;
            endcase

            if (take_rise) begin
                // The rising-edge sample is sample 1 of the new period.
                per_cnt_d = CNT_ONE;
                hi_cnt_d  = CNT_ONE;
                rise_d    = 1'b1;
                // The first rise after reset or no_signal only arms.
                if (armed_q) begin
                    period_d    = per_cnt_q;
                    high_time_d = hi_cnt_q;
                    meas_d      = 1'b1;
                end
                armed_d     = 1'b1;
                no_signal_d = 1'b0;
            end else begin
                if (per_cnt_q != CNT_MAX) begin
                    per_cnt_d   = per_cnt_q + CNT_ONE;
                    // Only the step into saturation flags no_signal, so a
                    // falling edge while saturated can still clear it.
                    sat_reached = (per_cnt_q == CNT_PRE);
                end
                if (state_d == ST_HIGH && hi_cnt_q != CNT_MAX) begin
                    hi_cnt_d = hi_cnt_q + CNT_ONE;
                end
            end

            if (take_fall) begin
                fall_d      = 1'b1;
                no_signal_d = 1'b0;
            end

            if (sat_reached) begin
                no_signal_d = 1'b1;
                armed_d     = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_UNKNOWN;
            per_cnt_q   <= '0;
            hi_cnt_q    <= '0;
            period_q    <= '0;
            high_time_q <= '0;
            armed_q     <= 1'b0;
            no_signal_q <= 1'b0;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
            meas_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            per_cnt_q   <= per_cnt_d;
            hi_cnt_q    <= hi_cnt_d;
            period_q    <= period_d;
            high_time_q <= high_time_d;
            armed_q     <= armed_d;
            no_signal_q <= no_signal_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
            meas_q      <= meas_d;
        end
    end

    assign level_out  = (state_q == ST_HIGH);
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign period     = period_q;
    assign high_time  = high_time_q;
    assign meas_valid = meas_q;
    assign no_signal  = no_signal_q;
    assign state_dbg  = state_q;

endmodule
